// File: rtl/core_input_ctrl_pkg.sv
// Shared definitions for the SHA-256 core input block buffer sequencer.
// Block geometry and the 2-bit controller state encoding.
package core_input_ctrl_pkg;

  localparam int BLK_WORDS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/core_input_ctrl.sv
// Input block buffer sequencer: fills the 16-word buffer from the loader and
// drains it to the SHA-256 core, allowing the next block to refill behind the read pointer.
module core_input_ctrl
  import core_input_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] in_data,
  input  logic        in_wr_en,
  output logic        in_full,
  output logic        err_overflow,
  output logic [31:0] buf_din,
  output logic        buf_wr_en,
  output logic [3:0]  buf_wr_addr,
  output logic        buf_rd_en,
  output logic [3:0]  buf_rd_addr,
  output logic        core_blk_ready,
  input  logic        core_start,
  output logic        core_word_valid,
  output logic [3:0]  core_word_idx,
  output logic        core_blk_done
);

  localparam logic [4:0] WR_FULL = 5'(BLK_WORDS);
  localparam logic [3:0] RD_LAST = 4'(BLK_WORDS - 1);

  state_e      state_q, state_d;
  logic [4:0]  wr_cnt_q, wr_cnt_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic        err_q, err_d;
  logic        word_valid_q, word_valid_d;
  logic [3:0]  word_idx_q, word_idx_d;
  logic        blk_done_q, blk_done_d;
  logic        in_full_s;
  logic        wr_accept_s;

  // Back-pressure depends only on state and counters, never on in_wr_en.
  always_comb begin
    in_full_s = 1'b1;
    case (state_q)
      ST_IDLE:  in_full_s = 1'b0;
      ST_FILL:  in_full_s = (wr_cnt_q >= WR_FULL);
      ST_READY: in_full_s = 1'b1;
      ST_DRAIN: in_full_s = !(wr_cnt_q < {1'b0, rd_cnt_q});
      default:  in_full_s = 1'b1;
    endcase
  end

  // A write landing on the reset edge is suppressed so reset never stores data.
  assign wr_accept_s = in_wr_en && !in_full_s && !RST;

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    err_d        = err_q | (in_wr_en & in_full_s);
    word_valid_d = (state_q == ST_DRAIN);
    word_idx_d   = rd_cnt_q;
    blk_done_d   = (state_q == ST_DRAIN) && (rd_cnt_q == RD_LAST);
    if (wr_accept_s) begin
      wr_cnt_d = wr_cnt_q + 5'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (wr_accept_s) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (wr_cnt_d == WR_FULL) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_READY: begin
        if (core_start) begin
          state_d  = ST_DRAIN;
          rd_cnt_d = 4'd0;
          wr_cnt_d = 5'd0;
        end else begin
          state_d  = ST_READY;
        end
      end
      ST_DRAIN: begin
        rd_cnt_d = rd_cnt_q + 4'd1;
        if (rd_cnt_q == RD_LAST) begin
          if (wr_cnt_d == WR_FULL) begin
            state_d = ST_READY;
          end else if (wr_cnt_d != 5'd0) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_cnt_d = 5'd0;
        rd_cnt_d = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= 5'd0;
      rd_cnt_q     <= 4'd0;
      err_q        <= 1'b0;
      word_valid_q <= 1'b0;
      word_idx_q   <= 4'd0;
      blk_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      err_q        <= err_d;
      word_valid_q <= word_valid_d;
      word_idx_q   <= word_idx_d;
      blk_done_q   <= blk_done_d;
    end
  end

  assign in_full         = in_full_s;
  assign err_overflow    = err_q;
  assign buf_din         = in_data;
  assign buf_wr_en       = wr_accept_s;
  assign buf_wr_addr     = wr_cnt_q[3:0];
  assign buf_rd_en       = (state_q == ST_DRAIN);
  assign buf_rd_addr     = rd_cnt_q;
  assign core_blk_ready  = (state_q == ST_READY);
  assign core_word_valid = word_valid_q;
  assign core_word_idx   = word_idx_q;
  assign core_blk_done   = blk_done_q;

endmodule

// File: tb/tb_core_input_ctrl.sv
// Directed bench for core_input_ctrl with a behavioural byte-swapping buffer
// and a scoreboard of expected drained words.
module tb_core_input_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] in_data = 32'd0;
  logic        in_wr_en = 1'b0;
  logic        core_start = 1'b0;
  logic        in_full, err_overflow, buf_wr_en, buf_rd_en;
  logic        core_blk_ready, core_word_valid, core_blk_done;
  logic [31:0] buf_din;
  logic [3:0]  buf_wr_addr, buf_rd_addr, core_word_idx;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] mem [16];
  logic [31:0] buf_dout;

  core_input_ctrl dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_wr_en(in_wr_en),
    .in_full(in_full), .err_overflow(err_overflow), .buf_din(buf_din),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr), .core_blk_ready(core_blk_ready),
    .core_start(core_start), .core_word_valid(core_word_valid),
    .core_word_idx(core_word_idx), .core_blk_done(core_blk_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Buffer model: synchronous write, 1-cycle registered read with byte swap.
  always @(posedge CLK) begin
    if (buf_wr_en === 1'b1) mem[buf_wr_addr] <= buf_din;
    if (buf_rd_en === 1'b1) buf_dout <= swap32(mem[buf_rd_addr]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every valid word is popped from the scoreboard.
  always @(negedge CLK) begin
    exp_t e;
    if (core_word_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_empty: observed word idx %0d expected no word", core_word_idx);
      end else begin
        e = sb_q.pop_front();
        chk("word_idx", 32'(core_word_idx), 32'(e.idx));
        chk("word_data", buf_dout, e.data);
        chk("blk_done", 32'(core_blk_done), 32'(e.idx == 4'd15));
      end
    end else if (RST === 1'b0) begin
      chk("done_without_valid", 32'(core_blk_done), 32'd0);
    end
    if (core_blk_done === 1'b1) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals;
    chk("rst_in_full", 32'(in_full), 32'd0);
    chk("rst_blk_ready", 32'(core_blk_ready), 32'd0);
    chk("rst_word_valid", 32'(core_word_valid), 32'd0);
    chk("rst_blk_done", 32'(core_blk_done), 32'd0);
    chk("rst_rd_en", 32'(buf_rd_en), 32'd0);
    chk("rst_wr_en", 32'(buf_wr_en), 32'd0);
    chk("rst_word_idx", 32'(core_word_idx), 32'd0);
    chk("rst_rd_addr", 32'(buf_rd_addr), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
  endtask

  task automatic apply_reset;
    RST = 1'b1;
    in_wr_en = 1'b0;
    core_start = 1'b0;
    cyc();
    cyc();
    RST = 1'b0;
    sb_q.delete();
  endtask

  task automatic write_word(input logic [31:0] d, input int addr);
    in_wr_en = 1'b1;
    in_data = d;
    #1;
    chk("wr_full", 32'(in_full), 32'd0);
    chk("wr_en", 32'(buf_wr_en), 32'd1);
    chk("wr_addr", 32'(buf_wr_addr), 32'(addr));
    sb_q.push_back('{idx: 4'(addr), data: swap32(d)});
    cyc();
    in_wr_en = 1'b0;
  endtask

  task automatic write_block(input logic [31:0] base);
    for (int k = 0; k < 16; k++) write_word(base + 32'(k), k);
    chk("blk_ready", 32'(core_blk_ready), 32'd1);
    chk("ready_full", 32'(in_full), 32'd1);
  endtask

  task automatic drain_check;
    int d0;
    d0 = done_cnt;
    core_start = 1'b1;
    cyc();
    core_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("drain_rd_en", 32'(buf_rd_en), 32'd1);
      chk("drain_rd_addr", 32'(buf_rd_addr), 32'(i));
      cyc();
    end
    chk("drain_end_rd_en", 32'(buf_rd_en), 32'd0);
    cyc();
    chk("drain_done_count", 32'(done_cnt - d0), 32'd1);
    chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int  w;
    int  d0;
    bit  found;
    logic acc;

    cyc();
    cyc();
    RST = 1'b0;
    check_reset_vals();

    // Single block
    write_block(32'h0000_0000);
    drain_check();
    chk("idle_after_drain_full", 32'(in_full), 32'd0);

    // Overlapped refill with in_wr_en held high
    write_block(32'h0000_0100);
    core_start = 1'b1;
    cyc();
    core_start = 1'b0;
    w = 0;
    for (int i = 0; i < 16; i++) begin
      in_wr_en = 1'b1;
      in_data = 32'h0000_0200 + 32'(w);
      #1;
      acc = (w < i);
      chk("ovl_full", 32'(in_full), 32'(!acc));
      chk("ovl_wr_en", 32'(buf_wr_en), 32'(acc));
      chk("ovl_rd_addr", 32'(buf_rd_addr), 32'(i));
      if (acc) begin
        chk("ovl_wr_addr", 32'(buf_wr_addr), 32'(w));
        sb_q.push_back('{idx: 4'(w), data: swap32(in_data)});
        w++;
      end
      cyc();
    end
    in_data = 32'h0000_0200 + 32'(w);
    #1;
    chk("ovl_fill_full", 32'(in_full), 32'd0);
    chk("ovl_fill_wr_addr", 32'(buf_wr_addr), 32'd15);
    sb_q.push_back('{idx: 4'(w), data: swap32(in_data)});
    cyc();
    in_wr_en = 1'b0;
    chk("ovl_ready", 32'(core_blk_ready), 32'd1);
    chk("ovl_err_set", 32'(err_overflow), 32'd1);
    drain_check();
    apply_reset();
    chk("ovl_err_cleared", 32'(err_overflow), 32'd0);

    // Spurious start in IDLE and at wr_cnt=7, then overflow
    core_start = 1'b1;
    cyc();
    core_start = 1'b0;
    chk("spur_idle_rd_en", 32'(buf_rd_en), 32'd0);
    for (int k = 0; k < 7; k++) write_word(32'h0000_0300 + 32'(k), k);
    core_start = 1'b1;
    cyc();
    core_start = 1'b0;
    chk("spur_fill_rd_en", 32'(buf_rd_en), 32'd0);
    chk("spur_fill_ready", 32'(core_blk_ready), 32'd0);
    chk("spur_fill_full", 32'(in_full), 32'd0);
    for (int k = 7; k < 16; k++) write_word(32'h0000_0300 + 32'(k), k);
    chk("ovf_ready", 32'(core_blk_ready), 32'd1);
    chk("ovf_err_before", 32'(err_overflow), 32'd0);
    in_wr_en = 1'b1;
    in_data = 32'hDEAD_BEEF;
    #1;
    chk("ovf_wr_dropped", 32'(buf_wr_en), 32'd0);
    cyc();
    in_wr_en = 1'b0;
    chk("ovf_err_set", 32'(err_overflow), 32'd1);
    drain_check();
    chk("ovf_err_sticky", 32'(err_overflow), 32'd1);
    apply_reset();
    check_reset_vals();

    // Reset mid-drain at word 5
    write_block(32'h0000_0500);
    core_start = 1'b1;
    cyc();
    core_start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      if (core_word_valid === 1'b1 && core_word_idx === 4'd5) found = 1'b1;
      else cyc();
    end
    chk("mid_drain_idx5_seen", 32'(found), 32'd1);
    RST = 1'b1;
    in_wr_en = 1'b1;
    in_data = 32'hBAD0_0000;
    #1;
    chk("rst_no_write", 32'(buf_wr_en), 32'd0);
    cyc();
    RST = 1'b0;
    in_wr_en = 1'b0;
    sb_q.delete();
    d0 = done_cnt;
    check_reset_vals();
    for (int t = 0; t < 4; t++) cyc();
    chk("mid_drain_no_done", 32'(done_cnt - d0), 32'd0);
    write_block(32'h0000_0600);
    drain_check();

    // Partial refill of 10 words during drain
    write_block(32'h0000_0700);
    core_start = 1'b1;
    cyc();
    core_start = 1'b0;
    w = 0;
    for (int i = 0; i < 16; i++) begin
      acc = (w < i) && (w < 10);
      in_wr_en = acc;
      in_data = 32'h0000_0800 + 32'(w);
      #1;
      chk("part_wr_en", 32'(buf_wr_en), 32'(acc));
      if (acc) begin
        sb_q.push_back('{idx: 4'(w), data: swap32(in_data)});
        w++;
      end
      cyc();
    end
    in_wr_en = 1'b0;
    chk("part_fill_full", 32'(in_full), 32'd0);
    chk("part_fill_ready", 32'(core_blk_ready), 32'd0);
    for (int k = 10; k < 16; k++) write_word(32'h0000_0800 + 32'(k), k);
    chk("part_ready", 32'(core_blk_ready), 32'd1);
    drain_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
